// File: rtl/crc_serial_engine.sv
// Bit-serial Galois-LFSR CRC engine with start/busy/done handshake and optional zero augmentation.
// Optional received-CRC compare (crc_exp/crc_ok) is built only when CRC_SERIAL_CHECK_EN is defined.
module crc_serial_engine #(
  parameter int               CRC_W     = 9,
  parameter int               DATA_W    = 10,
  parameter logic [CRC_W-1:0] POLY      = 'h103,
  parameter logic [CRC_W-1:0] INIT      = '0,
  parameter logic [CRC_W-1:0] XOR_OUT   = '0,
  parameter int               MSB_FIRST = 1,
  parameter int               AUGMENT   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [CRC_W-1:0]  crc_out
`ifdef CRC_SERIAL_CHECK_EN
  ,
  input  logic [CRC_W-1:0]  crc_exp,
  output logic              crc_ok
`endif
);

  localparam int N     = DATA_W + ((AUGMENT != 0) ? CRC_W : 0);
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    AUG   = 2'd2
  } state_t;

  state_t              stateQ;
  logic [CRC_W-1:0]    lfsrQ, lfsrD;
  logic [DATA_W-1:0]   shiftQ, shiftD;
  logic [CNT_W-1:0]    cntQ, cntD;
  logic                busyQ, doneQ;
  logic [CRC_W-1:0]    crcQ, crcD;
  logic                din, fb;
`ifdef CRC_SERIAL_CHECK_EN
  logic [CRC_W-1:0]    expQ;
  logic                okQ;
`endif

  // One LFSR step; augmentation bits feed zero into the divider.
  always_comb begin
    din    = 1'b0;
    if (stateQ == SHIFT) begin
      din = (MSB_FIRST != 0) ? shiftQ[DATA_W-1] : shiftQ[0];
    end
    fb     = lfsrQ[CRC_W-1] ^ din;
    lfsrD  = (lfsrQ << 1) ^ (fb ? POLY : '0);
    shiftD = (MSB_FIRST != 0) ? (shiftQ << 1) : (shiftQ >> 1);
    cntD   = cntQ + CNT_W'(1);
    crcD   = lfsrD ^ XOR_OUT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= IDLE;
      lfsrQ  <= '0;
      shiftQ <= '0;
      cntQ   <= '0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
      crcQ   <= '0;
`ifdef CRC_SERIAL_CHECK_EN
      expQ   <= '0;
      okQ    <= 1'b0;
`endif
    end else begin
      doneQ <= 1'b0;
      case (stateQ)
        IDLE: begin
          if (start) begin
            shiftQ <= data_in;
            lfsrQ  <= INIT;
            cntQ   <= '0;
            busyQ  <= 1'b1;
            stateQ <= SHIFT;
`ifdef CRC_SERIAL_CHECK_EN
            expQ   <= crc_exp;
`endif
          end
        end
        SHIFT, AUG: begin
          lfsrQ  <= lfsrD;
          shiftQ <= shiftD;
          cntQ   <= cntD;
          // Completion takes priority so AUGMENT=0 never visits AUG.
          if (cntQ == LAST_BIT) begin
            stateQ <= IDLE;
            busyQ  <= 1'b0;
            doneQ  <= 1'b1;
            crcQ   <= crcD;
`ifdef CRC_SERIAL_CHECK_EN
            okQ    <= (crcD == expQ);
`endif
          end else if ((AUGMENT != 0) && (stateQ == SHIFT) && (cntQ == DATA_LAST)) begin
            stateQ <= AUG;
          end
        end
        default: begin
          stateQ <= IDLE;
          busyQ  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busyQ;
  assign done    = doneQ;
  assign crc_out = crcQ;
`ifdef CRC_SERIAL_CHECK_EN
  assign crc_ok  = okQ;
`endif

endmodule

// File: tb/tb_crc_serial_engine.sv
// Scoreboard bench for crc_serial_engine: four parameter variants checked against a polynomial long-division model.
// Instances: 0 defaults, 1 INIT=1FF, 2 AUGMENT=1, 3 MSB_FIRST=0.
module tb_crc_serial_engine;

  localparam int W = 9;
  localparam int D = 10;
  localparam logic [W-1:0] POLY = 9'h103;
  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [D-1:0]      dataIn;
  logic [3:0]        startV, busyV, doneV;
  logic [3:0][W-1:0] crcOut;
`ifdef CRC_SERIAL_CHECK_EN
  logic [W-1:0]      crcExp;
  logic [3:0]        okV;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [W-1:0] expCrc [4][$];
  int           expCyc [4][$];
  logic         expOk  [4][$];

  always @(posedge clk) cyc <= cyc + 1;

  crc_serial_engine u0 (
    .clk(clk), .reset(reset), .start(startV[0]), .data_in(dataIn),
    .busy(busyV[0]), .done(doneV[0]), .crc_out(crcOut[0])
`ifdef CRC_SERIAL_CHECK_EN
    , .crc_exp(crcExp), .crc_ok(okV[0])
`endif
  );

  crc_serial_engine #(.INIT(9'h1FF)) u1 (
    .clk(clk), .reset(reset), .start(startV[1]), .data_in(dataIn),
    .busy(busyV[1]), .done(doneV[1]), .crc_out(crcOut[1])
`ifdef CRC_SERIAL_CHECK_EN
    , .crc_exp(crcExp), .crc_ok(okV[1])
`endif
  );

  crc_serial_engine #(.AUGMENT(1)) u2 (
    .clk(clk), .reset(reset), .start(startV[2]), .data_in(dataIn),
    .busy(busyV[2]), .done(doneV[2]), .crc_out(crcOut[2])
`ifdef CRC_SERIAL_CHECK_EN
    , .crc_exp(crcExp), .crc_ok(okV[2])
`endif
  );

  crc_serial_engine #(.MSB_FIRST(0)) u3 (
    .clk(clk), .reset(reset), .start(startV[3]), .data_in(dataIn),
    .busy(busyV[3]), .done(doneV[3]), .crc_out(crcOut[3])
`ifdef CRC_SERIAL_CHECK_EN
    , .crc_exp(crcExp), .crc_ok(okV[3])
`endif
  );

  // Remainder of (INIT*x^n + S(x)*x^W) mod G, where S is the transmitted bit stream, first bit highest degree.
  function automatic logic [W-1:0] refCrc(int k, logic [D-1:0] data);
    logic [127:0] dividend;
    logic [127:0] gen;
    logic [W-1:0] init;
    bit           msb, aug;
    int           n;
    init = (k == 1) ? 9'h1FF : 9'h000;
    msb  = (k != 3);
    aug  = (k == 2);
    n    = D + (aug ? W : 0);
    dividend = '0;
    for (int i = 0; i < D; i++) begin
      dividend[n - 1 - i + W] = msb ? data[D-1-i] : data[i];
    end
    dividend = dividend ^ (128'(init) << n);
    gen = 128'(POLY) | (128'd1 << W);
    for (int deg = n + W - 1; deg >= W; deg--) begin
      if (dividend[deg]) dividend = dividend ^ (gen << (deg - W));
    end
    return dividend[W-1:0];
  endfunction

  function automatic int bitsOf(int k);
    return (k == 2) ? D + W : D;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Called at a negedge with instance k idle; pushes the expected result and completion cycle.
  task automatic applyStimulus(int k, logic [D-1:0] data);
    dataIn    = data;
    startV[k] = 1'b1;
    expCrc[k].push_back(refCrc(k, data));
    expCyc[k].push_back(cyc + 1 + bitsOf(k));
`ifdef CRC_SERIAL_CHECK_EN
    expOk[k].push_back(refCrc(k, data) == crcExp);
`endif
    @(negedge clk);
    startV[k] = 1'b0;
  endtask

  task automatic waitAllDone();
    int guard = 0;
    while ((expCrc[0].size() + expCrc[1].size() + expCrc[2].size() + expCrc[3].size()) != 0
           && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= LIMIT) begin
      total++;
      bad++;
      $display("[TB] FAIL timeout waiting for done actual=pending required=empty");
      for (int k = 0; k < 4; k++) begin
        expCrc[k].delete(); expCyc[k].delete(); expOk[k].delete();
      end
    end
  endtask

  task automatic waitDonePulse(int k);
    int guard = 0;
    while (doneV[k] !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("done_seen", {31'd0, doneV[k]}, 32'd1);
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (doneV[k] === 1'b1) begin
        if (expCrc[k].size() == 0) begin
          checkOutput($sformatf("spurious_done%0d", k), 32'd1, 32'd0);
        end else begin
          checkOutput($sformatf("crc%0d", k), crcOut[k], expCrc[k].pop_front());
          checkOutput($sformatf("done_cycle%0d", k), cyc, expCyc[k].pop_front());
`ifdef CRC_SERIAL_CHECK_EN
          checkOutput($sformatf("crc_ok%0d", k), {31'd0, okV[k]}, {31'd0, expOk[k].pop_front()});
`endif
        end
      end
    end
  end

  initial begin
    logic [D-1:0] d;
    reset  = 1'b1;
    startV = '0;
    dataIn = '0;
`ifdef CRC_SERIAL_CHECK_EN
    crcExp = '0;
`endif
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checkOutput("reset_busy", {31'd0, busyV[k]}, 32'd0);
      checkOutput("reset_done", {31'd0, doneV[k]}, 32'd0);
      checkOutput("reset_crc", crcOut[k], 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Known vector: busy for 10 cycles, then done with 9'h004.
    applyStimulus(0, 10'b1000000000);
    for (int i = 0; i < 10; i++) begin
      checkOutput("busy_run", {31'd0, busyV[0]}, 32'd1);
      checkOutput("no_early_done", {31'd0, doneV[0]}, 32'd0);
      @(negedge clk);
    end
    checkOutput("busy_end", {31'd0, busyV[0]}, 32'd0);
    checkOutput("done_pulse", {31'd0, doneV[0]}, 32'd1);
    checkOutput("crc_known", crcOut[0], 32'h004);
    @(negedge clk);
    checkOutput("done_single", {31'd0, doneV[0]}, 32'd0);
    checkOutput("crc_hold", crcOut[0], 32'h004);

    applyStimulus(0, '0);
    waitAllDone();
    checkOutput("crc_zero", crcOut[0], 32'h000);
    applyStimulus(1, '0);
    waitAllDone();

    // Starts while busy are ignored; a start in the done cycle is accepted.
    applyStimulus(0, 10'h2A5);
    repeat (2) @(negedge clk);
    dataIn = 10'h0F3; startV[0] = 1'b1;
    @(negedge clk);
    startV[0] = 1'b0;
    repeat (3) @(negedge clk);
    dataIn = 10'h311; startV[0] = 1'b1;
    @(negedge clk);
    startV[0] = 1'b0;
    waitDonePulse(0);
    applyStimulus(0, 10'h155);
    checkOutput("busy_restart", {31'd0, busyV[0]}, 32'd1);
    waitAllDone();

    // Reset mid-run: outputs clear and no done follows.
    applyStimulus(0, 10'h3C7);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    expCrc[0].delete(); expCyc[0].delete(); expOk[0].delete();
    @(negedge clk);
    checkOutput("abort_busy", {31'd0, busyV[0]}, 32'd0);
    checkOutput("abort_done", {31'd0, doneV[0]}, 32'd0);
    checkOutput("abort_crc", crcOut[0], 32'd0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    applyStimulus(0, 10'h1B9);
    waitAllDone();

    applyStimulus(2, 10'b1000000000);
    waitAllDone();

`ifdef CRC_SERIAL_CHECK_EN
    crcExp = 9'h004;
    applyStimulus(0, 10'b1000000000);
    waitAllDone();
    checkOutput("ok_match", {31'd0, okV[0]}, 32'd1);
    crcExp = 9'h005;
    applyStimulus(0, 10'b1000000000);
    waitAllDone();
    checkOutput("ok_mismatch", {31'd0, okV[0]}, 32'd0);
`endif

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20; i++) begin
        d = D'($urandom);
`ifdef CRC_SERIAL_CHECK_EN
        crcExp = $urandom_range(0, 1) ? refCrc(k, d) : W'($urandom);
`endif
        applyStimulus(k, d);
        waitAllDone();
      end
    end
    for (int i = 0; i < 200; i++) begin
      applyStimulus(3, D'($urandom));
      waitAllDone();
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_serial_engine.md
Name: crc_serial_engine

Overview:
- Parametrised bit-serial CRC engine: Galois LFSR, one message bit per clock.
- Generalises the fixed 9-bit/10-bit serial CRC to configurable CRC width, polynomial, message width, init/xor-out values and bit order.
- Adds a start/busy/done handshake, an optional zero-augmentation phase, and a stable registered result.
- Sits between a parallel message source and a framing/transmit block that appends the check bits.

Parameters:
- CRC_W, 9, CRC register width (2..32).
- DATA_W, 10, message width in bits (1..64).
- POLY, 9'h103, generator polynomial without the implicit x^CRC_W term. Bit i set means feedback XOR into LFSR bit i.
- INIT, 0, LFSR value loaded at start.
- XOR_OUT, 0, value XORed into the final LFSR state to form crc_out.
- MSB_FIRST, 1, 1 shifts data_in[DATA_W-1] first; 0 shifts data_in[0] first.
- AUGMENT, 0, 1 shifts CRC_W extra zero bits after the message (long-division form).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- data_in  in  DATA_W  message; captured on the accepted start edge
- busy  out  1  high while a computation is in progress
- done  out  1  one-cycle pulse when crc_out is updated
- crc_out  out  CRC_W  registered result; holds until the next completion

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, crc_out=0, LFSR=0, bit counter=0, shift register=0. Reset overrides everything, including mid-computation; the aborted computation produces no done and crc_out reads 0.
- States: IDLE, SHIFT, AUG (AUG exists only when AUGMENT=1).
- Total bit count N = DATA_W + AUGMENT*CRC_W. The counter is $clog2(N+1) bits wide.
- Start accept (edge E0, state IDLE, start=1):
  - data_in -> shift register; LFSR <= INIT; counter <= 0.
  - State -> SHIFT; busy <= 1; done <= 0.
- IDLE with start=0: no change; done deasserts after its single cycle.
- Each edge in SHIFT or AUG processes one bit:
  - din = next message bit in MSB_FIRST order (0 in AUG).
  - fb = LFSR[CRC_W-1] ^ din.
  - LFSR <= {LFSR[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
  - counter increments.
- Transitions:
  - SHIFT -> AUG after the DATA_W-th bit when AUGMENT=1.
  - The N-th bit edge (E_N) returns to IDLE.
- Completion at E_N: crc_out <= next LFSR ^ XOR_OUT; done <= 1 for exactly one cycle; busy <= 0.
- Latency: done high in the cycle after edge E_N, i.e. N clocks after the start-sample edge. Throughput: one message per N+1 clocks at best.
- start while busy: ignored; data_in is not re-sampled.
- start in the cycle done is high: accepted, since state is already IDLE. crc_out keeps the previous result until the new completion.
- crc_out never shows intermediate LFSR values.

Optional Feature:
- Macro: CRC_SERIAL_CHECK_EN.
- Defined:
  - Adds input crc_exp [CRC_W-1:0], sampled together with data_in at start.
  - Adds output crc_ok, registered and updated at E_N: 1 if crc_out == captured crc_exp, else 0.
  - crc_ok resets to 0 and holds between completions.
- Undefined: neither port exists; no compare logic is built.

Test Plan:
- Defaults, reset, data_in=10'b1000000000, start pulse -> busy high 10 cycles; done one cycle 10 clocks after start edge; crc_out=9'h004.
- Defaults, data_in=0 -> crc_out=9'h000. Then INIT=9'h1FF instance with data_in=0 -> crc_out matches the bench bit-serial reference model.
- start re-asserted at cycles 3 and 7 of a busy run with a different data_in -> ignored; result equals first message's CRC. start in the done cycle -> new run begins, second done 10 clocks later.
- reset asserted at bit 5 of a run -> next edge: busy=0, done=0, crc_out=0. No done follows; a fresh start afterwards completes normally.
- AUGMENT=1, CRC_W=9, DATA_W=10, data_in=10'b1000000000 -> done after 19 clocks; crc_out equals the model's long-division remainder. MSB_FIRST=0 sweep of 200 random vectors matches the model.
- CRC_SERIAL_CHECK_EN defined: crc_exp=9'h004 with data 10'b1000000000 -> crc_ok=1; crc_exp=9'h005 -> crc_ok=0.
